uni_shift_reg: RTL and testbench
================================

// Module: uni_shift_reg
// PURPOSE
//   Parameterised universal shift register: hold, shift right, shift left, or parallel load,
//   selected each cycle by a 2-bit mode code.
//   Generic datapath building block for serialisers, deserialisers and bit-rotation staging.
//   Single clock domain; output driven directly by the register.
// PARAMETERS
//   WIDTH  4  register width in bits (WIDTH >= 2)
// PORTS
//   clk          in   1      clock; all state updates on rising edge
//   clr          in   1      reset; synchronous, active-low (clr==0 at posedge clears register)
//   serialright  in   1      serial input for right shift; enters at MSB q[WIDTH-1]
//   serialleft   in   1      serial input for left shift; enters at LSB q[0]
//   in           in   WIDTH  parallel load data
//   select       in   2      mode: 00 hold, 01 shift right, 10 shift left, 11 parallel load
//   q            out  WIDTH  register contents (registered output, no combinational path)
// BEHAVIOUR
//   - Interface: one clock; reset is synchronous and active-low.
//   - Reset: at posedge clk with clr==0, q <= 0. Reset overrides select and all data inputs.
//   - Reset value of q is all zeros.
//   - q is unknown before the first reset edge.
//   - With clr==1, at each posedge clk:
//       select==00  q <= q                               (hold)
//       select==01  q <= {serialright, q[WIDTH-1:1]}     (shift right; q[0] discarded)
//       select==10  q <= {q[WIDTH-2:0], serialleft}      (shift left; q[WIDTH-1] discarded)
//       select==11  q <= in                              (parallel load)
//   - Latency: one clock from input sample to q update.
//   - No handshake. Mode and data are sampled on every edge.
//   - Inputs change between edges without glitching q.
//   - No wrap-around: the shifted-out bit is lost, not rotated. Rotation is built by feeding
//     q[0] to serialright, or q[WIDTH-1] to serialleft, externally.
//   - Serial inputs are ignored in modes 00 and 11.
//   - in is ignored in modes 00, 01 and 10.
//   - Reset mid-shift clears immediately at that edge. The next edge with clr==1 resumes per
//     select from 0.
//   - X/Z on select is not required to be handled. A case default holds q.
// TESTING
//   1. clr=0 for 1 edge, any select/in -> q=4'b0000; remains 0 while select=00 after clr=1.
//   2. clr=1, in=4'b1010, select=11, 1 edge -> q=4'b1010.
//   3. from 1010, select=00, 3 edges, in toggled -> q stays 1010.
//   4. from 1010, select=01, serialright=1 -> q=1101, then 1110, then 1111.
//   5. from 1010, select=10, serialleft=1 -> q=0101, then 1011; serialleft=0 -> 0110.
//   6. q=1101, select=01 held, clr=0 for one edge -> q=0000;
//      clr=1 next edge with serialright=1 -> q=1000.
//   Also: back-to-back mode switch 11->01->10 each one cycle; check every intermediate value.

Source files
------------

// File: rtl/uni_shift_reg.sv
// Universal shift register: hold, shift right, shift left or parallel load,
// chosen each cycle by a 2-bit mode code. q is driven straight from the
// state register, so it has no combinational path from any input.
module uni_shift_reg #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             serialright,
    input  logic             serialleft,
    input  logic [WIDTH-1:0] in,
    input  logic [1:0]       select,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_q_next;

    // Next-value selection; the default arm holds so an undecoded mode is harmless
    always_comb begin
        w_q_next = r_q;
        case (select)
            2'b00:   w_q_next = r_q;
            2'b01:   w_q_next = {serialright, r_q[WIDTH-1:1]};
            2'b10:   w_q_next = {r_q[WIDTH-2:0], serialleft};
            2'b11:   w_q_next = in;
            default: w_q_next = r_q;
        endcase
    end

    // State register; clr low clears regardless of mode or data
    always_ff @(posedge clk) begin
        if (!clr) begin
            r_q <= '0;
        end else begin
            r_q <= w_q_next;
        end
    end

    assign q = r_q;

endmodule

// File: tb/tb_uni_shift_reg.sv
// Bench for uni_shift_reg: directed sequences with fixed expected values,
// then randomized traffic compared against an arithmetic reference model.
module tb_uni_shift_reg;

    localparam int W = 4;

    logic         clk;
    logic         clr;
    logic         serialright;
    logic         serialleft;
    logic [W-1:0] in;
    logic [1:0]   select;
    logic [W-1:0] q;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state, tracked as a plain integer
    int  m_q;
    bit  m_known;

    uni_shift_reg #(.WIDTH(W)) dut (
        .clk        (clk),
        .clr        (clr),
        .serialright(serialright),
        .serialleft (serialleft),
        .in         (in),
        .select     (select),
        .q          (q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    // Reference behaviour expressed as integer arithmetic on the register value
    function automatic int model_next(input int cur, input bit c, input int sel,
                                      input bit sr, input bit sl, input int d);
        int full;
        full = 1 << W;
        if (!c) return 0;
        case (sel)
            1:       return (cur / 2) + (sr ? full / 2 : 0);
            2:       return ((cur * 2) % full) + (sl ? 1 : 0);
            3:       return d % full;
            default: return cur;
        endcase
    endfunction

    // Apply inputs at the falling edge, clock once, update model, return at next falling edge
    task automatic cyc(input logic c, input logic [1:0] s, input logic sr, input logic sl,
                       input logic [W-1:0] d);
        clr = c; select = s; serialright = sr; serialleft = sl; in = d;
        @(posedge clk);
        m_q = model_next(m_q, c, int'(s), sr, sl, int'(d));
        if (!c) m_known = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        logic [W-1:0] exp_q;
        clr = 1'b1; select = 2'b00; serialright = 1'b0; serialleft = 1'b0; in = '0;
        m_q = 0; m_known = 1'b0;
        @(negedge clk);

        // Reset with busy inputs, then hold
        cyc(1'b0, 2'b11, 1'b1, 1'b1, 4'hF); check("reset", q, 4'b0000);
        cyc(1'b1, 2'b00, 1'b1, 1'b1, 4'hF); check("hold_after_reset0", q, 4'b0000);
        cyc(1'b1, 2'b00, 1'b0, 1'b1, 4'h7); check("hold_after_reset1", q, 4'b0000);

        // Parallel load
        cyc(1'b1, 2'b11, 1'b0, 1'b0, 4'b1010); check("load", q, 4'b1010);

        // Hold while in and serial inputs toggle
        cyc(1'b1, 2'b00, 1'b1, 1'b0, 4'b0101); check("hold0", q, 4'b1010);
        cyc(1'b1, 2'b00, 1'b0, 1'b1, 4'b1111); check("hold1", q, 4'b1010);
        cyc(1'b1, 2'b00, 1'b1, 1'b1, 4'b0000); check("hold2", q, 4'b1010);

        // Shift right, ones entering at MSB
        cyc(1'b1, 2'b01, 1'b1, 1'b0, 4'h0); check("shr0", q, 4'b1101);
        cyc(1'b1, 2'b01, 1'b1, 1'b0, 4'h0); check("shr1", q, 4'b1110);
        cyc(1'b1, 2'b01, 1'b1, 1'b0, 4'h0); check("shr2", q, 4'b1111);

        // Shift left from 1010
        cyc(1'b1, 2'b11, 1'b0, 1'b0, 4'b1010); check("reload", q, 4'b1010);
        cyc(1'b1, 2'b10, 1'b0, 1'b1, 4'hF); check("shl0", q, 4'b0101);
        cyc(1'b1, 2'b10, 1'b0, 1'b1, 4'hF); check("shl1", q, 4'b1011);
        cyc(1'b1, 2'b10, 1'b1, 1'b0, 4'hF); check("shl2", q, 4'b0110);

        // Reset in the middle of a right shift, then resume from zero
        cyc(1'b1, 2'b11, 1'b0, 1'b0, 4'b1101); check("load_1101", q, 4'b1101);
        cyc(1'b0, 2'b01, 1'b1, 1'b1, 4'hF); check("midshift_reset", q, 4'b0000);
        cyc(1'b1, 2'b01, 1'b1, 1'b0, 4'h0); check("resume_shr", q, 4'b1000);

        // Back-to-back mode switch load -> right -> left
        cyc(1'b1, 2'b11, 1'b1, 1'b0, 4'b1010); check("b2b_load", q, 4'b1010);
        cyc(1'b1, 2'b01, 1'b0, 1'b1, 4'b0000); check("b2b_shr", q, 4'b0101);
        cyc(1'b1, 2'b10, 1'b0, 1'b1, 4'b1111); check("b2b_shl", q, 4'b1011);

        // Rotation built externally by feeding shifted-out bit back
        cyc(1'b1, 2'b11, 1'b0, 1'b0, 4'b0001); check("rot_load", q, 4'b0001);
        cyc(1'b1, 2'b01, q[0], 1'b0, 4'h0);    check("rot_r", q, 4'b1000);
        cyc(1'b1, 2'b10, 1'b0, q[W-1], 4'h0);  check("rot_l", q, 4'b0001);

        // Randomized traffic against the reference model
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 19) != 0), 2'($urandom_range(0, 3)),
                1'($urandom), 1'($urandom), W'($urandom));
            exp_q = W'(m_q);
            if (m_known) check("random", q, exp_q);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
